hazard_scoreboard: RTL and testbench

// - Producer-side counterpart of the ID-stage forwarding path. Tracks destination registers of issued

---
 rtl/hazard_scoreboard_pkg.sv | 22 ++
 rtl/hazard_scoreboard_counter.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 146 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the ID-stage hazard scoreboard: register index
// widths used by decode/WB and the scoreboard sizing defaults.
package hazard_scoreboard_pkg;

    // Register index widths, identical to the core's decode fields.
    localparam int RS1_WIDTH = 5;
    localparam int RS2_WIDTH = 5;
    localparam int RD_WIDTH  = 5;

    // Scoreboard sizing defaults.
    localparam int SB_NUM_REGS     = 32;
    localparam int SB_CNT_W        = 2;
    localparam int SB_MAX_INFLIGHT = 4;

    // Width needed to hold 0..max_inflight inclusive.
    function automatic int sb_inf_width(input int max_inflight);
        return (max_inflight < 1) ? 1 : $clog2(max_inflight + 1);
    endfunction

    localparam int SB_INF_W = sb_inf_width(SB_MAX_INFLIGHT);

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// sb_counter: per-register saturating up/down counter of outstanding
// long-latency writes. inc and dec together leave the count unchanged;
// an inc at full or a dec at zero is dropped (the top reports the error).
module sb_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic full
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Next-count selection: saturate in both directions, hold on inc+dec.
    always_comb begin
        cnt_next = cnt_reg;
        if (inc && !dec && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end else if (dec && !inc && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    // Count register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign zero = (cnt_reg == '0);
    assign full = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks destination registers of issued long-latency
// writers (loads, multi-cycle ops) and stalls ID while a decoding
// instruction reads, or WAW-overwrites, one still in flight. Write-back of
// a tracked register releases it for the ID check on the following cycle.
//
// Event bookkeeping:
//   - track  : issue_fire & write_reg_id & long_lat_id & rd_id != 0
//   - retire : wb_valid & rd_wb != 0
//   - A track and a retire to the same register in one cycle cancel out:
//     no counter moves, inflight_cnt is unchanged and no error is raised.
//   - Otherwise a retire of an idle register, or a track that would
//     overflow its counter or the global in-flight limit, is dropped and
//     sets the sticky sb_err. A retire in the same cycle makes room for a
//     track when the global limit is reached.
//   - inflight_cnt always equals the sum of all per-register counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS     = SB_NUM_REGS,
    parameter int CNT_W        = SB_CNT_W,
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   issue_valid,
    input  logic [RS1_WIDTH-1:0]                   rs1_id,
    input  logic [RS2_WIDTH-1:0]                   rs2_id,
    input  logic                                   rs1_used,
    input  logic                                   rs2_used,
    input  logic [RD_WIDTH-1:0]                    rd_id,
    input  logic                                   write_reg_id,
    input  logic                                   long_lat_id,
    input  logic                                   issue_fire,
    input  logic                                   wb_valid,
    input  logic [RD_WIDTH-1:0]                    rd_wb,
    output logic                                   stall_id,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]      inflight_cnt,
    output logic                                   sb_err
);

    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);

    // Per-register status flags. Entry 0 is x0: permanently idle.
    logic [NUM_REGS-1:0] zero_vec;
    logic [NUM_REGS-1:0] full_vec;

    logic [INF_W-1:0] inflight_reg;
    logic [INF_W-1:0] inflight_next;
    logic             err_reg;
    logic             err_next;

    logic track_ev;
    logic retire_ev;
    logic pair_ev;
    logic track_ok;
    logic retire_ok;
    logic track_bad;
    logic retire_bad;
    logic inf_full;

    logic rs1_busy;
    logic rs2_busy;
    logic rd_block;

    assign zero_vec[0] = 1'b1;
    assign full_vec[0] = 1'b0;

    // Raw events as seen on the decode and write-back ports.
    assign track_ev  = issue_fire && write_reg_id && long_lat_id && (rd_id != '0);
    assign retire_ev = wb_valid && (rd_wb != '0);
    assign pair_ev   = track_ev && retire_ev && (rd_id == rd_wb);
    assign inf_full  = (inflight_reg == INF_MAX);

    // Decide which events actually change state this cycle.
    always_comb begin
        retire_ok  = 1'b0;
        track_ok   = 1'b0;
        retire_bad = 1'b0;
        track_bad  = 1'b0;
        if (!pair_ev) begin
            retire_ok  = retire_ev && !zero_vec[rd_wb];
            track_ok   = track_ev && !full_vec[rd_id] && (!inf_full || retire_ok);
            retire_bad = retire_ev && !retire_ok;
            track_bad  = track_ev && !track_ok;
        end
    end

    // One saturating counter per architectural register except x0.
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg_cnt
            logic inc_g;
            logic dec_g;

            assign inc_g = track_ok  && (rd_id == RD_WIDTH'(gi));
            assign dec_g = retire_ok && (rd_wb == RD_WIDTH'(gi));

            sb_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk  (clk),
                .rst  (rst),
                .inc  (inc_g),
                .dec  (dec_g),
                .zero (zero_vec[gi]),
                .full (full_vec[gi])
            );
        end
    endgenerate

    // Global in-flight count and sticky error, next-state values.
    always_comb begin
        inflight_next = inflight_reg;
        if (track_ok && !retire_ok) begin
            inflight_next = inflight_reg + 1'b1;
        end else if (retire_ok && !track_ok) begin
            inflight_next = inflight_reg - 1'b1;
        end
        err_next = err_reg || retire_bad || track_bad;
    end

    // Global in-flight count and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            inflight_reg <= inflight_next;
            err_reg      <= err_next;
        end
    end

    // Hazard check from registered state only: a write-back in this same
    // cycle does not release the register until the next cycle.
    always_comb begin
        rs1_busy = rs1_used && !zero_vec[rs1_id];
        rs2_busy = rs2_used && !zero_vec[rs2_id];
        rd_block = write_reg_id && long_lat_id && (rd_id != '0)
                   && (full_vec[rd_id] || inf_full);
        stall_id = issue_valid && (rs1_busy || rs2_busy || rd_block);
    end

    assign inflight_cnt = inflight_reg;
    assign sb_err       = err_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a directed vector table covering load-use,
// x0, WAW, simultaneous track/retire, capacity and error cases, followed
// by randomized traffic compared against an integer-level reference model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd_id;
    logic       write_reg_id;
    logic       long_lat_id;
    logic       issue_fire;
    logic       wb_valid;
    logic [4:0] rd_wb;
    logic       stall_id;
    logic [2:0] inflight_cnt;
    logic       sb_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .rd_id        (rd_id),
        .write_reg_id (write_reg_id),
        .long_lat_id  (long_lat_id),
        .issue_fire   (issue_fire),
        .wb_valid     (wb_valid),
        .rd_wb        (rd_wb),
        .stall_id     (stall_id),
        .inflight_cnt (inflight_cnt),
        .sb_err       (sb_err)
    );

    typedef struct {
        logic iv;
        int   rs1;
        int   rs2;
        logic u1;
        logic u2;
        int   rd;
        logic wr;
        logic ll;
        logic fire;
        logic wbv;
        int   rdwb;
        logic exp_stall;
        int   exp_inf;
        logic exp_err;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: outstanding writes per register.
    int  m_cnt[32];
    int  m_inf;
    bit  m_err;
    localparam int M_CNT_MAX = 3;
    localparam int M_INF_MAX = 4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void addv(input logic iv, input int rs1, input int rs2,
                                 input logic u1, input logic u2, input int rd,
                                 input logic wr, input logic ll, input logic fire,
                                 input logic wbv, input int rdwb,
                                 input logic es, input int ei, input logic ee);
        vec_t v;
        v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rd = rd; v.wr = wr; v.ll = ll; v.fire = fire; v.wbv = wbv;
        v.rdwb = rdwb; v.exp_stall = es; v.exp_inf = ei; v.exp_err = ee;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic iv, input int rs1, input int rs2,
                         input logic u1, input logic u2, input int rd,
                         input logic wr, input logic ll, input logic fire,
                         input logic wbv, input int rdwb);
        issue_valid  = iv;
        rs1_id       = 5'(rs1);
        rs2_id       = 5'(rs2);
        rs1_used     = u1;
        rs2_used     = u2;
        rd_id        = 5'(rd);
        write_reg_id = wr;
        long_lat_id  = ll;
        issue_fire   = fire;
        wb_valid     = wbv;
        rd_wb        = 5'(rdwb);
    endtask

    function automatic void model_clear();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_inf = 0;
        m_err = 0;
    endfunction

    function automatic bit model_stall(input logic iv, input int rs1, input int rs2,
                                       input logic u1, input logic u2, input int rd,
                                       input logic wr, input logic ll);
        bit hz;
        hz = (u1 && rs1 != 0 && m_cnt[rs1] > 0)
          || (u2 && rs2 != 0 && m_cnt[rs2] > 0)
          || (wr && ll && rd != 0 && (m_cnt[rd] == M_CNT_MAX || m_inf == M_INF_MAX));
        return iv && hz;
    endfunction

    function automatic void model_step(input bit trk, input int rd, input bit ret, input int rdwb);
        bit rok;
        bit tok;
        if (trk && ret && rd == rdwb) return;
        rok = ret && m_cnt[rdwb] > 0;
        tok = trk && m_cnt[rd] < M_CNT_MAX && (m_inf < M_INF_MAX || rok);
        if ((ret && !rok) || (trk && !tok)) m_err = 1;
        if (rok) begin m_cnt[rdwb]--; m_inf--; end
        if (tok) begin m_cnt[rd]++; m_inf++; end
    endfunction

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        drive(1, 5, 5, 1, 1, 5, 1, 1, 0, 0, 0);
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset held two cycles with a hazard-looking instruction in ID.
        do_reset(2);
        drive(1, 5, 5, 1, 1, 5, 1, 1, 0, 0, 0);
        @(negedge clk);
        chk("reset_stall", 32'(stall_id), 0);
        chk("reset_inflight", 32'(inflight_cnt), 0);
        chk("reset_err", 32'(sb_err), 0);
        $display("reset: stall=%0d inflight=%0d err=%0d", stall_id, inflight_cnt, sb_err);
        @(posedge clk);
        #1;

        //   iv rs1 rs2 u1 u2 rd wr ll fi wbv rdwb | stall inf err
        // load-use on x5, no same-cycle WB bypass
        addv(1, 0, 0, 0, 0, 5, 1, 1, 1, 0, 0,  0, 0, 0);
        addv(1, 5, 0, 1, 0,10, 1, 0, 0, 0, 0,  1, 1, 0);
        addv(1, 5, 0, 1, 0,10, 1, 0, 0, 1, 5,  1, 1, 0);
        addv(1, 5, 0, 1, 0,10, 1, 0, 1, 0, 0,  0, 0, 0);
        // x0 never tracked
        addv(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0,  0, 0, 0);
        addv(1, 0, 0, 1, 0, 8, 0, 0, 1, 0, 0,  0, 0, 0);
        // WAW saturation on x7
        addv(1, 0, 0, 0, 0, 7, 1, 1, 1, 0, 0,  0, 0, 0);
        addv(1, 0, 0, 0, 0, 7, 1, 1, 1, 0, 0,  0, 1, 0);
        addv(1, 0, 0, 0, 0, 7, 1, 1, 1, 0, 0,  0, 2, 0);
        addv(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0,  1, 3, 0);
        addv(1, 0, 0, 0, 0, 7, 1, 1, 0, 1, 7,  1, 3, 0);
        addv(1, 0, 0, 0, 0, 7, 1, 1, 1, 0, 0,  0, 2, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, 3, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, 2, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, 1, 0);
        // simultaneous track and retire on x9
        addv(1, 0, 0, 0, 0, 9, 1, 1, 1, 0, 0,  0, 0, 0);
        addv(1, 0, 0, 0, 0, 9, 1, 1, 1, 1, 9,  0, 1, 0);
        addv(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9,  0, 1, 0);
        // capacity: x1..x4 fill the in-flight budget
        addv(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0,  0, 0, 0);
        addv(1, 0, 0, 0, 0, 2, 1, 1, 1, 0, 0,  0, 1, 0);
        addv(1, 0, 0, 0, 0, 3, 1, 1, 1, 0, 0,  0, 2, 0);
        addv(1, 0, 0, 0, 0, 4, 1, 1, 1, 0, 0,  0, 3, 0);
        addv(1, 0, 3, 0, 1,11, 1, 0, 0, 0, 0,  1, 4, 0);
        addv(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0,  1, 4, 0);
        addv(1, 0, 0, 0, 0, 6, 1, 1, 0, 1, 2,  1, 4, 0);
        addv(1, 0, 0, 0, 0, 6, 1, 1, 1, 0, 0,  0, 3, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 4, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,  0, 3, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4,  0, 2, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6,  0, 1, 0);
        // error: retire of untracked x12, sticky; rd_wb=0 ignored
        addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,12,  0, 0, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1);
        addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
                  vecs[i].rd, vecs[i].wr, vecs[i].ll, vecs[i].fire,
                  vecs[i].wbv, vecs[i].rdwb);
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), 32'(stall_id), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_inflight", i), 32'(inflight_cnt), 32'(vecs[i].exp_inf));
            chk($sformatf("vec%0d_err", i), 32'(sb_err), 32'(vecs[i].exp_err));
            $display("vec %0d: stall=%0d inflight=%0d err=%0d", i, stall_id, inflight_cnt, sb_err);
            @(posedge clk);
            #1;
        end

        // Reset clears the sticky error.
        do_reset(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("err_cleared", 32'(sb_err), 0);
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model.
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic iv, u1, u2, wr, ll, fire, wbv, rs;
            int   rs1, rs2, rd, rdwb;
            bit   ms;
            rs   = (cyc % 200 == 199);
            iv   = ($urandom_range(3) != 0);
            rs1  = $urandom_range(7);
            rs2  = $urandom_range(7);
            u1   = $urandom_range(1);
            u2   = $urandom_range(1);
            rd   = $urandom_range(7);
            wr   = ($urandom_range(3) != 0);
            ll   = ($urandom_range(2) != 0);
            ms   = model_stall(iv, rs1, rs2, u1, u2, rd, wr, ll);
            fire = iv && !ms && ($urandom_range(3) != 0);
            wbv  = 1'b0;
            rdwb = 0;
            if ($urandom_range(2) == 0) begin
                if ($urandom_range(9) == 0) begin
                    wbv  = 1'b1;
                    rdwb = $urandom_range(15);
                end else begin
                    int start = $urandom_range(7);
                    for (int k = 0; k < 8; k++) begin
                        int r = (start + k) % 8;
                        if (!wbv && r != 0 && m_cnt[r] > 0) begin
                            wbv  = 1'b1;
                            rdwb = r;
                        end
                    end
                end
            end
            rst = rs;
            drive(iv, rs1, rs2, u1, u2, rd, wr, ll, fire, wbv, rdwb);
            @(negedge clk);
            chk("rnd_stall", 32'(stall_id), 32'(ms));
            chk("rnd_inflight", 32'(inflight_cnt), 32'(m_inf));
            chk("rnd_err", 32'(sb_err), 32'(m_err));
            $display("rnd %0d: rst=%0d fire=%0d rd=%0d wb=%0d/%0d stall=%0d inflight=%0d err=%0d",
                     cyc, rs, fire, rd, wbv, rdwb, stall_id, inflight_cnt, sb_err);
            if (rs) model_clear();
            else model_step(fire && wr && ll && rd != 0, rd, wbv && rdwb != 0, rdwb);
            @(posedge clk);
            #1;
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
